// File: rtl/gs_div_pkg.sv
// Shared definitions for the Goldschmidt Q1.15 divider controller.
// Optional feature macro used by gs_div_ctrl: GS_DIV_EARLY_TERM_EN.
package gs_div_pkg;

    localparam int          WIDTH    = 16;
    localparam int          FRAC     = 15;
    localparam logic [15:0] ONE_Q15  = 16'h8000;
    localparam logic [15:0] NORM_MIN = 16'h4000;
    localparam logic [15:0] ERR_Q    = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Divisor must sit in [0.5,1): top bit clear, next bit set.
    function automatic logic is_norm(input logic [WIDTH-1:0] d);
        return (d[WIDTH-1] == 1'b0) && (d[WIDTH-2] == 1'b1);
    endfunction

endpackage

// File: rtl/gs_mul_q15.sv
// Unsigned Q1.15 x Q1.15 multiply, truncated back to Q1.15 (product bits [30:15]).
module gs_mul_q15
    import gs_div_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] prod;
    logic               unused_prod;

    assign prod        = a * b;
    assign p           = prod[WIDTH+FRAC-1:FRAC];
    // Integer overflow bit and dropped fraction bits are discarded (truncation).
    assign unused_prod = ^{prod[2*WIDTH-1], prod[FRAC-1:0]};

endmodule

// File: rtl/gs_div_ctrl.sv
// Goldschmidt divider controller: q = n/d in unsigned Q1.15, fixed ITER iterations.
// Optional build macro GS_DIV_EARLY_TERM_EN: stop as soon as D has converged to ~1.0.
module gs_div_ctrl
    import gs_div_pkg::*;
#(
    parameter int ITER = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q_out,
    output logic             err
);

    localparam logic [3:0] LAST = 4'(ITER - 1);

    state_t           state;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] f_term;
    logic [WIDTH-1:0] n_next;
    logic [WIDTH-1:0] d_next;
    logic [3:0]       cnt;
    logic             conv;

    // 2 - D in Q1.15 is simply the two's complement of D (mod 2^16).
    assign f_term = ~d_reg + 16'd1;

`ifdef GS_DIV_EARLY_TERM_EN
    // D has reached 1.0 within one LSB; further iterations cannot change N.
    assign conv = (d_reg == 16'h7FFF) || (d_reg == ONE_Q15);
`else
    assign conv = 1'b0;
`endif

    gs_mul_q15 u_mul_n (.a(n_reg), .b(f_term), .p(n_next));
    gs_mul_q15 u_mul_d (.a(d_reg), .b(f_term), .p(d_next));

    // Control FSM with registered busy/done/q_out/err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            n_reg <= '0;
            d_reg <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            q_out <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        n_reg <= n_in;
                        d_reg <= d_in;
                        cnt   <= '0;
                        err   <= 1'b0;
                        if (!is_norm(d_in)) begin
                            // Unnormalized divisor: flag and finish without iterating.
                            err   <= 1'b1;
                            q_out <= ERR_Q;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (conv) begin
                        q_out <= n_reg;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        n_reg <= n_next;
                        d_reg <= d_next;
                        cnt   <= cnt + 4'd1;
                        if (cnt == LAST) begin
                            q_out <= n_next;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gs_div_ctrl.sv
// Directed self-checking bench for gs_div_ctrl (ITER=4).
module tb_gs_div_ctrl;

    localparam int ITER = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] n_in  = '0;
    logic [15:0] d_in  = '0;
    logic        busy;
    logic        done;
    logic [15:0] q_out;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    gs_div_ctrl #(.ITER(ITER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .n_in  (n_in),
        .d_in  (d_in),
        .busy  (busy),
        .done  (done),
        .q_out (q_out),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one op; optionally inject a second start with other operands during RUN.
    task automatic run_op(input string tag, input logic [15:0] n, input logic [15:0] d,
                          input int exp_lat, input int exp_busy, input logic [15:0] exp_q,
                          input logic exp_err, input bit inject);
        int lat;
        int bcnt;
        int dcnt;
        @(negedge clk);
        n_in  = n;
        d_in  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_in  = 16'h1234;
        d_in  = 16'h5000;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (inject && lat == 1) begin
                n_in  = 16'h2000;
                d_in  = 16'h4000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, "_lat"},  lat,   exp_lat);
        chk({tag, "_busy"}, bcnt,  exp_busy);
        chk({tag, "_q"},    q_out, exp_q);
        chk({tag, "_err"},  err,   exp_err);
        chk({tag, "_bsyd"}, busy,  1'b0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk({tag, "_1pls"}, dcnt,  0);
        chk({tag, "_hold"}, q_out, exp_q);
    endtask

    initial begin
        int dcnt;
        int gap;
        int t;

        // Reset state
        #1;
        chk("rst_busy", busy,  1'b0);
        chk("rst_done", done,  1'b0);
        chk("rst_err",  err,   1'b0);
        chk("rst_q",    q_out, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 0.5/0.75 -> 0.6666 ; 0.25/0.5 -> 0.5 (truncation leaves 0x3FFF)
        run_op("d4000_6000", 16'h4000, 16'h6000, ITER, ITER, 16'h5555, 1'b0, 1'b0);
        run_op("d2000_4000", 16'h2000, 16'h4000, ITER, ITER, 16'h3FFF, 1'b0, 1'b0);

        // Unnormalized divisors
        run_op("dzero", 16'h1000, 16'h0000, 0, 0, 16'hFFFF, 1'b1, 1'b0);
        chk("dzero_errhold", err, 1'b1);
        run_op("d8000", 16'h1000, 16'h8000, 0, 0, 16'hFFFF, 1'b1, 1'b0);

        // Start during RUN is ignored; err cleared by the accepted start
        run_op("inject", 16'h4000, 16'h6000, ITER, ITER, 16'h5555, 1'b0, 1'b1);

        // Reset two cycles after e0
        @(negedge clk);
        n_in  = 16'h4000;
        d_in  = 16'h6000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", busy,  1'b0);
        chk("mid_done", done,  1'b0);
        chk("mid_q",    q_out, 16'h0000);
        chk("mid_err",  err,   1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("mid_quiet", dcnt, 0);
        run_op("after_rst", 16'h3000, 16'h6000, ITER, ITER, 16'h3FFF, 1'b0, 1'b0);

        // Already-converged divisor
`ifdef GS_DIV_EARLY_TERM_EN
        run_op("d7fff", 16'h3000, 16'h7FFF, 1, 1, 16'h3000, 1'b0, 1'b0);
`else
        run_op("d7fff", 16'h3000, 16'h7FFF, ITER, ITER, 16'h3000, 1'b0, 1'b0);
`endif

        // Start held high: back-to-back ops, ITER+2 cycles between done pulses
        @(negedge clk);
        n_in  = 16'h2000;
        d_in  = 16'h4000;
        start = 1'b1;
        t = 0;
        while (!done && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("held_first", done, 1'b1);
        gap = 0;
        @(negedge clk);
        gap++;
        while (!done && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        chk("held_gap", gap,   ITER + 2);
        chk("held_q",   q_out, 16'h3FFF);
        start = 1'b0;
        t = 0;
        while ((busy || done) && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("held_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gs_div_ctrl.md
GS_DIV_CTRL -- requirements
Module: gs_div_ctrl

Interface
REQ-001 SHALL have parameter ITER, default 4, meaning the fixed Goldschmidt iteration count, legal range 1..8.
REQ-002 SHALL have one clock; reset is asynchronous and active-low: port clk.
REQ-003 SHALL have port rst_n  in  1  async active-low reset.
REQ-004 SHALL have port start  in  1  request; sampled only in IDLE.
REQ-005 SHALL have port n_in  in  16  numerator, unsigned Q1.15, legal range [0,1).
REQ-006 SHALL have port d_in  in  16  divisor, unsigned Q1.15, normalized to [0.5,1), i.e. 0x4000..0x7FFF.
REQ-007 SHALL have port busy  out  1  high while in RUN.
REQ-008 SHALL have port done  out  1  single-cycle completion pulse.
REQ-009 SHALL have port q_out  out  16  quotient, unsigned Q1.15, held until the next completion.
REQ-010 SHALL have port err  out  1  divisor-not-normalized flag, held until the next accepted start.

Function
REQ-011 SHALL implement the states IDLE, RUN and DONE.
REQ-012 IDLE with start=1 at edge e0 SHALL load N_reg<=n_in, D_reg<=d_in, clear the iteration counter, clear err, and go to RUN.
REQ-013 At edge e0, if d_in[15]=1 or d_in[14]=0 (including d_in=0), the block SHALL set err<=1 and q_out<=16'hFFFF and go directly to DONE, with no iterations.
REQ-014 Each RUN edge SHALL compute F=(~D_reg+1) mod 2^16, which is 2-D in Q1.15, and update N_reg<=(N_reg*F)[30:15] and D_reg<=(D_reg*F)[30:15], with truncation and no rounding.
REQ-015 The edge performing the ITER-th iteration SHALL load q_out with the updated N value and go to DONE; for a valid request, done is high in the cycle after edge e0+ITER.
REQ-016 DONE SHALL assert done for exactly one cycle, then go to IDLE; busy=0 in DONE.
REQ-017 start while in RUN or DONE SHALL be ignored, with no queuing.
REQ-018 start held high continuously SHALL launch a new operation on the first IDLE edge after DONE.
REQ-019 Accuracy: for legal inputs with ITER>=4, q_out SHALL be within +/-2 LSB of floor(n*2^15/d).

Reset
REQ-020 While rst_n=0, the block SHALL immediately force state=IDLE, busy=0, done=0, err=0, q_out=0, N_reg=0, D_reg=0, and counter=0.
REQ-021 Reset mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-022 Macro GS_DIV_EARLY_TERM_EN, when defined: at any RUN edge where D_reg is 16'h7FFF or 16'h8000 (converged), q_out<=N_reg unchanged and the state goes to DONE, skipping remaining iterations.
REQ-023 Without GS_DIV_EARLY_TERM_EN, exactly ITER iterations SHALL always run; the comparator logic SHALL be absent.

Structure
REQ-024 Shared package gs_div_pkg SHALL hold WIDTH=16, FRAC=15, ONE_Q15=16'h8000, NORM_MIN=16'h4000, the state enum type, and the ERR_Q=16'hFFFF constant.
REQ-025 The Q1.15 multiply-and-truncate SHALL be a sub-module gs_mul_q15 (16x16->32 unsigned, output bits [30:15]), instantiated twice (N path, D path).
REQ-026 The 2-D term SHALL be a two's-complement of D_reg with no extra pipeline stage.

Verification
REQ-027 ITER=4, n=0x4000, d=0x6000 -> done in the cycle after e0+4, q_out 0x5555 +/-2, err=0.
REQ-028 n=0x2000, d=0x4000 -> q_out 0x4000 +/-2; busy high for exactly 4 cycles.
REQ-029 d=0x0000, then d=0x8000 -> err=1, q_out=0xFFFF, done in the cycle after e0, busy never high.
REQ-030 A start pulse during RUN with different operands -> ignored; result matches the first operands, with a single done pulse.
REQ-031 rst_n low two cycles after e0 -> outputs zero at once, no done pulse; the next start n=0x3000, d=0x6000 -> q_out 0x4000 +/-2.
REQ-032 With GS_DIV_EARLY_TERM_EN defined, n=0x3000, d=0x7FFF -> done in the cycle after e0+1, q_out 0x3000; without the macro, done follows e0+ITER.
